wb_fifo_slave: RTL and testbench
================================

Name: wb_fifo_slave

Overview:
Wishbone classic (B.1-style) slave that exposes a 32-bit synchronous FIFO through a small register window. It is the responder end of the point-to-point interconnect and sits where the 8x32 register slave sits today. A master pushes words by writing DATA and pops them by reading DATA. STATUS and CTRL registers report and manage the FIFO state. Configurable wait states let the bench exercise master wait handling.

Parameters:
DW, 32, data bus width (fixed 32 in this revision)
AW, 3, address width of ADR_I
DEPTH, 8, FIFO depth; must be a power of 2, range 2..128
WAIT, 0, wait-state cycles inserted before a response (0..15)

Ports:
CLK_I  in  1  system clock; all logic is on the rising edge
RST_I  in  1  synchronous, active-high reset
CYC_I  in  1  bus cycle in progress
STB_I  in  1  strobe; request is valid when CYC_I & STB_I
WE_I   in  1  1 = write, 0 = read
ADR_I  in  AW  register address
DAT_I  in  DW  write data
DAT_O  out DW  read data; valid only while ACK_O is high, otherwise 0
ACK_O  out 1  normal termination
RTY_O  out 1  retry termination (FIFO full on push, empty on pop)
ERR_O  out 1  error termination (bad address or illegal access)

Behaviour:
- Interface: one clock, CLK_I. Reset RST_I is synchronous and active-high.
- Register map:
  - 0 DATA: write pushes; read pops.
  - 1 STATUS, read-only:
    - [7:0] count
    - [8] empty
    - [9] full
    - [10] overflow (sticky)
    - [11] underflow (sticky)
    - other bits 0
  - 2 CTRL: write bit0 flushes the FIFO; write bit1 clears both stickies. Read returns 0 with ACK.
  - 3..7: reserved.
- Reset: ACK_O, RTY_O, ERR_O and DAT_O are 0. FIFO is empty, both stickies are 0, FSM is in IDLE.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: on a clock edge with CYC_I & STB_I high, latch ADR/WE/DAT. Go to WAIT (cnt = WAIT-1) if WAIT > 0, otherwise go to RESP.
  - WAIT: decrement cnt; go to RESP when cnt = 0. If CYC_I or STB_I is low at any edge, abort to IDLE with no response and no side effects.
  - RESP: exactly one of ACK/RTY/ERR is high for one cycle, then return to IDLE.
  - The IDLE cycle after RESP samples the next request; no back-to-back double termination is possible.
- Latency: response is high in the cycle starting WAIT+1 edges after the request is sampled.
- Side effects (push, pop, flush, sticky clear) happen on the same edge that raises the response.
- Push while full: RTY, no push, overflow set.
- Push with full and pop never coincide, since there is a single port.
- Pop while empty: RTY, DAT_O = 0, underflow set.
- Write to STATUS, or any access to addresses 3..7: ERR, no state change.
- A flush while entries are present resets pointers and count to 0 and does not touch the stickies unless bit1 is also set. Both bits may be set together.
- Pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits, zero-extended into STATUS[7:0].
- Reset mid-transaction: the transaction is aborted, no response is given, and all state returns to reset values.

Decomposition:
- Package wb_fifo_slave_pkg holds:
  - address constants ADR_DATA=0, ADR_STATUS=1, ADR_CTRL=2
  - STATUS bit indices and CTRL bit indices
  - the FSM state encoding (IDLE/WAIT/RESP).
- Sub-module wb_sfifo: DEPTH x DW register array with push, pop, flush, dout, count, full and empty. It has no bus knowledge.
- wb_fifo_slave contains only the bus FSM, decode and the sticky flags.

Test Plan:
1. Reset, then read STATUS -> ACK, DAT_O = 0x00000100. All terminations were 0 during reset.
2. Push 0..7 to DATA -> 8 ACKs; STATUS = 0x00000208. 9th push of 0xDEAD -> RTY; STATUS = 0x00000608.
3. Pop 8 times -> data 0..7 in order with ACK. 9th pop -> RTY with DAT_O = 0; STATUS = 0x00000D00 (empty, overflow, underflow).
4. With WAIT=2: push -> ACK exactly 3 cycles after STB is sampled. Drop STB after 1 cycle on the next push -> no termination and count unchanged.
5. Read address 5 -> ERR for 1 cycle; write STATUS -> ERR; STATUS unchanged. Write CTRL = 0x3 with 3 entries held -> STATUS = 0x00000100.
6. Wrap test: push 5/pop 5, then push 0x10..0x17 and pop 8 -> 0x10..0x17 in order. Assert RST_I during WAIT -> no response, and FIFO is empty afterwards.

Source files
------------

// File: rtl/wb_fifo_slave_pkg.sv
// wb_fifo_slave_pkg: register addresses, STATUS/CTRL bit indices and bus FSM state encoding
package wb_fifo_slave_pkg;
  localparam int ADR_DATA = 0;
  localparam int ADR_STATUS = 1;
  localparam int ADR_CTRL = 2;
  localparam int STAT_EMPTY = 8;
  localparam int STAT_FULL = 9;
  localparam int STAT_OVF = 10;
  localparam int STAT_UDF = 11;
  localparam int CTRL_FLUSH = 0;
  localparam int CTRL_CLR = 1;
  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_e;
endpackage

// File: rtl/wb_fifo_slave_if.sv
// wb_fifo_slave_if: Wishbone classic bus (CYC/STB/WE/ADR/DAT_I in, DAT_O/ACK/RTY/ERR out) with master/slave modports
interface wb_fifo_slave_if #(
  parameter int AW = 3,
  parameter int DW = 32
);
  logic          CYC_I;
  logic          STB_I;
  logic          WE_I;
  logic [AW-1:0] ADR_I;
  logic [DW-1:0] DAT_I;
  logic [DW-1:0] DAT_O;
  logic          ACK_O;
  logic          RTY_O;
  logic          ERR_O;
  modport slave (input CYC_I, STB_I, WE_I, ADR_I, DAT_I, output DAT_O, ACK_O, RTY_O, ERR_O);
  modport master (output CYC_I, STB_I, WE_I, ADR_I, DAT_I, input DAT_O, ACK_O, RTY_O, ERR_O);
endinterface

// File: rtl/wb_sfifo.sv
// wb_sfifo: DEPTH x DW synchronous FIFO; ports clk, rst, push, pop, flush, din -> dout, count, full, empty
module wb_sfifo #(
  parameter int DW = 32,
  parameter int DEPTH = 8,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout,
  output logic [PW:0]   count,
  output logic          full,
  output logic          empty
);
  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_q] = din;
    wr_d = flush ? '0 : wr_q + PW'(push);
    rd_d = flush ? '0 : rd_q + PW'(pop);
    cnt_d = flush ? '0 : cnt_q + (PW+1)'(push) - (PW+1)'(pop);
  end
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (rst) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
  end
  assign dout = mem_q[rd_q];
  assign count = cnt_q;
  assign full = cnt_q == (PW+1)'(DEPTH);
  assign empty = cnt_q == '0;
endmodule

// File: rtl/wb_fifo_slave.sv
// wb_fifo_slave: Wishbone classic slave exposing a FIFO via DATA/STATUS/CTRL; ports CLK_I, RST_I, bus (slave modport)
module wb_fifo_slave
  import wb_fifo_slave_pkg::*;
#(
  parameter int DW = 32,
  parameter int AW = 3,
  parameter int DEPTH = 8,
  parameter int WAIT = 0
) (
  input logic CLK_I,
  input logic RST_I,
  wb_fifo_slave_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [3:0] WAIT_M1 = WAIT > 0 ? 4'(WAIT - 1) : 4'd0;
  state_e        state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] adr_q, adr_d;
  logic [DW-1:0] wdat_q, wdat_d, dat_q, dat_d, status, dout;
  logic          ack_q, ack_d, rty_q, rty_d, err_q, err_d, ovf_q, ovf_d, udf_q, udf_d;
  logic          req, fire, is_data, is_status, is_ctrl, bad, retry, push, pop, flush, clr;
  logic [PW:0]   count;
  logic          full, empty;
  wb_sfifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .clk(CLK_I), .rst(RST_I), .push(push), .pop(pop), .flush(flush), .din(wdat_d),
    .dout(dout), .count(count), .full(full), .empty(empty)
  );
  always_comb begin
    req = bus.CYC_I & bus.STB_I;
    fire = req & ((state_q == S_WAIT) ? (cnt_q == '0) : (state_q == S_IDLE && WAIT == 0));
    we_d = state_q == S_IDLE ? bus.WE_I : we_q;
    adr_d = state_q == S_IDLE ? bus.ADR_I : adr_q;
    wdat_d = state_q == S_IDLE ? bus.DAT_I : wdat_q;
    is_data = adr_d == AW'(ADR_DATA);
    is_status = adr_d == AW'(ADR_STATUS);
    is_ctrl = adr_d == AW'(ADR_CTRL);
    bad = (is_status & we_d) | ~(is_data | is_status | is_ctrl);
    retry = is_data & (we_d ? full : empty);
    push = fire & is_data & we_d & ~full;
    pop = fire & is_data & ~we_d & ~empty;
    flush = fire & is_ctrl & we_d & wdat_d[CTRL_FLUSH];
    clr = fire & is_ctrl & we_d & wdat_d[CTRL_CLR];
    status = '0;
    status[7:0] = 8'(count);
    status[STAT_EMPTY] = empty;
    status[STAT_FULL] = full;
    status[STAT_OVF] = ovf_q;
    status[STAT_UDF] = udf_q;
    ack_d = fire & ~bad & ~retry;
    rty_d = fire & retry;
    err_d = fire & bad;
    dat_d = (~ack_d | we_d) ? '0 : is_data ? dout : is_status ? status : '0;
    ovf_d = ~clr & (ovf_q | (rty_d & we_d));
    udf_d = ~clr & (udf_q | (rty_d & ~we_d));
    cnt_d = state_q == S_IDLE ? WAIT_M1 : cnt_q - 4'(state_q == S_WAIT);
    state_d = state_q == S_RESP ? S_IDLE :
              !req ? S_IDLE :
              state_q == S_WAIT ? (cnt_q == '0 ? S_RESP : S_WAIT) :
              WAIT > 0 ? S_WAIT : S_RESP;
  end
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      we_q <= 1'b0;
      adr_q <= '0;
      wdat_q <= '0;
      dat_q <= '0;
      ack_q <= 1'b0;
      rty_q <= 1'b0;
      err_q <= 1'b0;
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
      adr_q <= adr_d;
      wdat_q <= wdat_d;
      dat_q <= dat_d;
      ack_q <= ack_d;
      rty_q <= rty_d;
      err_q <= err_d;
      ovf_q <= ovf_d;
      udf_q <= udf_d;
    end
  end
  assign bus.DAT_O = dat_q;
  assign bus.ACK_O = ack_q;
  assign bus.RTY_O = rty_q;
  assign bus.ERR_O = err_q;
endmodule

// File: tb/tb_wb_fifo_slave.sv
// tb_wb_fifo_slave: scoreboard bench for wb_fifo_slave with WAIT=0 (dut0) and WAIT=2 (dut1) instances
module tb_wb_fifo_slave;
  localparam logic [2:0] ACK = 3'b100;
  localparam logic [2:0] RTY = 3'b010;
  localparam logic [2:0] ERR = 3'b001;
  typedef struct {
    string       nm;
    logic [2:0]  t;
    logic [31:0] d;
    int          lat;
    int          t0;
  } exp_t;
  logic        clk = 1'b0;
  logic        rst [2];
  logic        cyc [2];
  logic        stb [2];
  logic        we [2];
  logic [2:0]  adr [2];
  logic [31:0] wdat [2];
  logic [2:0]  term [2];
  logic [31:0] dato [2];
  exp_t        q0[$];
  exp_t        q1[$];
  int          cyc_n = 0;
  int          tmo_n = 0;
  int          tmo_seen = 0;
  int          vec = 0;
  int          fails = 0;
  logic        done = 1'b0;
  wb_fifo_slave_if #(.AW(3), .DW(32)) if0 ();
  wb_fifo_slave_if #(.AW(3), .DW(32)) if1 ();
  assign if0.CYC_I = cyc[0];
  assign if0.STB_I = stb[0];
  assign if0.WE_I = we[0];
  assign if0.ADR_I = adr[0];
  assign if0.DAT_I = wdat[0];
  assign if1.CYC_I = cyc[1];
  assign if1.STB_I = stb[1];
  assign if1.WE_I = we[1];
  assign if1.ADR_I = adr[1];
  assign if1.DAT_I = wdat[1];
  assign term[0] = {if0.ACK_O, if0.RTY_O, if0.ERR_O};
  assign term[1] = {if1.ACK_O, if1.RTY_O, if1.ERR_O};
  assign dato[0] = if0.DAT_O;
  assign dato[1] = if1.DAT_O;
  wb_fifo_slave #(.DW(32), .AW(3), .DEPTH(8), .WAIT(0)) u0 (.CLK_I(clk), .RST_I(rst[0]), .bus(if0.slave));
  wb_fifo_slave #(.DW(32), .AW(3), .DEPTH(8), .WAIT(2)) u1 (.CLK_I(clk), .RST_I(rst[1]), .bus(if1.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;
  task automatic xfer(input int d, input logic w, input logic [2:0] a, input logic [31:0] wd,
                      input logic [2:0] et, input logic [31:0] ed, input string nm);
    exp_t e;
    int n;
    e.nm = nm;
    e.t = et;
    e.d = ed;
    e.lat = (d == 0) ? 1 : 3;
    e.t0 = cyc_n;
    if (d == 0) q0.push_back(e);
    else q1.push_back(e);
    cyc[d] = 1'b1;
    stb[d] = 1'b1;
    we[d] = w;
    adr[d] = a;
    wdat[d] = wd;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (term[d] == 3'b000 && n < 20);
    if (term[d] == 3'b000) tmo_n++;
    cyc[d] = 1'b0;
    stb[d] = 1'b0;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input int d, input logic [2:0] a, input logic [31:0] wd, input logic [2:0] et, input string nm);
    xfer(d, 1'b1, a, wd, et, 32'h0, nm);
  endtask
  task automatic rd(input int d, input logic [2:0] a, input logic [2:0] et, input logic [31:0] ed, input string nm);
    xfer(d, 1'b0, a, 32'h0, et, ed, nm);
  endtask
  always @(negedge clk) begin
    exp_t e;
    logic [2:0] tm;
    logic [31:0] dt;
    for (int d = 0; d < 2; d++) begin
      tm = term[d];
      dt = dato[d];
      if (rst[d]) begin
        vec++;
        if (tm !== 3'b000 || dt !== 32'h0) begin
          fails++;
          $display("FAIL reset_quiet dut%0d term=%b dat=%h expected term=000 dat=0", d, tm, dt);
        end
      end else if (tm != 3'b000) begin
        vec++;
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          fails++;
          $display("FAIL unexpected_term dut%0d term=%b dat=%h expected no termination", d, tm, dt);
        end else begin
          if (d == 0) e = q0.pop_front();
          else e = q1.pop_front();
          if (tm !== e.t || dt !== e.d || cyc_n - e.t0 != e.lat) begin
            fails++;
            $display("FAIL %s dut%0d term=%b dat=%h lat=%0d expected term=%b dat=%h lat=%0d",
                     e.nm, d, tm, dt, cyc_n - e.t0, e.t, e.d, e.lat);
          end
        end
      end
    end
    if (tmo_n != tmo_seen) begin
      vec++;
      fails++;
      $display("FAIL timeout no termination within 20 cycles (count %0d expected 0)", tmo_n);
      tmo_seen = tmo_n;
    end
    if (cyc_n > 5000) begin
      fails++;
      $display("FAIL watchdog cycles=%0d expected <= 5000", cyc_n);
      $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
      $finish;
    end
    if (done) begin
      vec++;
      if (q0.size() + q1.size() != 0) begin
        fails++;
        $display("FAIL pending_expectations got %0d expected 0", q0.size() + q1.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vec, fails);
      $finish;
    end
  end
  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      cyc[d] = 1'b0;
      stb[d] = 1'b0;
      we[d] = 1'b0;
      adr[d] = 3'd0;
      wdat[d] = 32'h0;
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    rd(0, 3'd1, ACK, 32'h0000_0100, "status_after_reset");
    for (int i = 0; i < 8; i++) wr(0, 3'd0, 32'(i), ACK, $sformatf("push_%0d", i));
    rd(0, 3'd1, ACK, 32'h0000_0208, "status_full");
    wr(0, 3'd0, 32'h0000_DEAD, RTY, "push_while_full");
    rd(0, 3'd1, ACK, 32'h0000_0608, "status_overflow");
    for (int i = 0; i < 8; i++) rd(0, 3'd0, ACK, 32'(i), $sformatf("pop_%0d", i));
    rd(0, 3'd0, RTY, 32'h0, "pop_while_empty");
    rd(0, 3'd1, ACK, 32'h0000_0D00, "status_both_sticky");
    rd(0, 3'd5, ERR, 32'h0, "read_reserved_5");
    wr(0, 3'd1, 32'hFFFF_FFFF, ERR, "write_status");
    wr(0, 3'd7, 32'h1234_5678, ERR, "write_reserved_7");
    rd(0, 3'd1, ACK, 32'h0000_0D00, "status_after_err");
    for (int i = 0; i < 3; i++) wr(0, 3'd0, 32'hA0 + 32'(i), ACK, "push_three");
    rd(0, 3'd1, ACK, 32'h0000_0C03, "status_three");
    wr(0, 3'd2, 32'h1, ACK, "ctrl_flush_only");
    rd(0, 3'd1, ACK, 32'h0000_0D00, "status_flush_keeps_sticky");
    for (int i = 0; i < 3; i++) wr(0, 3'd0, 32'hB0 + 32'(i), ACK, "push_three_again");
    wr(0, 3'd2, 32'h3, ACK, "ctrl_flush_clear");
    rd(0, 3'd1, ACK, 32'h0000_0100, "status_after_ctrl3");
    rd(0, 3'd2, ACK, 32'h0, "read_ctrl");
    for (int i = 0; i < 5; i++) wr(0, 3'd0, 32'hC0 + 32'(i), ACK, "wrap_push5");
    for (int i = 0; i < 5; i++) rd(0, 3'd0, ACK, 32'hC0 + 32'(i), $sformatf("wrap_pop5_%0d", i));
    for (int i = 0; i < 8; i++) wr(0, 3'd0, 32'h10 + 32'(i), ACK, "wrap_push8");
    rd(0, 3'd1, ACK, 32'h0000_0208, "status_wrap_full");
    for (int i = 0; i < 8; i++) rd(0, 3'd0, ACK, 32'h10 + 32'(i), $sformatf("wrap_pop_%0d", i));
    rd(0, 3'd1, ACK, 32'h0000_0100, "status_wrap_empty");
    wr(1, 3'd0, 32'h55, ACK, "wait2_push");
    cyc[1] = 1'b1;
    stb[1] = 1'b1;
    we[1] = 1'b1;
    adr[1] = 3'd0;
    wdat[1] = 32'h77;
    @(posedge clk);
    #1;
    cyc[1] = 1'b0;
    stb[1] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rd(1, 3'd1, ACK, 32'h0000_0001, "wait2_status_after_abort");
    wr(1, 3'd0, 32'h66, ACK, "wait2_push2");
    cyc[1] = 1'b1;
    stb[1] = 1'b1;
    we[1] = 1'b1;
    adr[1] = 3'd0;
    wdat[1] = 32'h88;
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    cyc[1] = 1'b0;
    stb[1] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rd(1, 3'd1, ACK, 32'h0000_0100, "wait2_status_after_reset");
    rd(1, 3'd0, RTY, 32'h0, "wait2_pop_after_reset");
    done = 1'b1;
  end
endmodule
